datapath_pipe: RTL
==================

Name: datapath_pipe

Overview:
Parametrised successor of the single-cycle register-file/ALU datapath. It adds configurable data width, N external input channels (generalising the button/accelerometer muxes), and a one-stage execute pipeline with a valid/ready handshake, operand and carry bypass, and a stall input. It sits between the control FSM/instruction source and the memory interface.

Parameters:
WIDTH, 16, data/register width (>=8)
NIN, 2, number of external input channels on ext_in
SELW, derived = clog2(NIN+2), width of src_sel (localparam, not overridable)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  instruction offered
in_ready  out  1  block accepts when in_valid&in_ready
instr  in  16  [15:12] opcode, [11:8] Rdest, [7:4] op ext, [3:0] Rsrc/imm
src_sel  in  SELW  result source: 0 ALU, 1 mem_in, 2+k ext channel k
wb_en  in  1  write result to Rdest
flags_en  in  1  update flags from ALU
stall  in  1  freeze pipeline
mem_in  in  WIDTH  memory read data, sampled in EX cycle
ext_in  in  NIN*WIDTH  channel k = bits [k*WIDTH +: WIDTH]
a_out  out  WIDTH  registered Rdest operand in EX (memory address)
b_out  out  WIDTH  registered B operand in EX (store data)
wb_valid  out  1  EX instruction will write the regfile at the next edge
wb_dest  out  4  EX destination register
wb_data  out  WIDTH  EX muxed result
flags_out  out  5  {C,L,F,Z,N} = bits [4:0]

Behaviour:
- 16 registers of WIDTH; R0 is not hardwired.
- in_ready = ~stall (combinational).
- Decode happens in the accept cycle. On the accept edge, the EX register captures valid, a, b, op, dest, src_sel, wb_en, flags_en.
- EX cycle: ALU computes combinationally; result muxed by src_sel. src_sel > NIN+1 gives result 0.
- At the next edge (if ~stall): the regfile is written when wb_valid; flags are written when EX valid & flags_en & op is listed.
- Latency: accept at edge t; regfile/flags update at edge t+1. Throughput is 1/cycle.
- Encoding:
  - opcode 0000: register form; op = ext; B = R[Rsrc].
  - opcode 1000, ext 0100: LSH by signed R[Rsrc][4:0] (positive = left, negative = logical right).
  - opcode 1000, ext[7:5] = 000: LSHI; instr[4] selects direction (0 left, 1 right); amount = instr[3:0].
  - Other opcodes: immediate form; op = opcode; B = instr[7:0], sign-extended for ADD/ADDC/SUB/CMP and zero-extended for AND/OR/XOR/MOV.
- Ops and results:
  - 0001 AND
  - 0010 OR
  - 0011 XOR
  - 0101 ADD
  - 0111 ADDC (a+b+C)
  - 1001 SUB (a-b)
  - 1011 CMP (no regfile write, even if wb_en)
  - 1101 MOV (result = b)
  - Unlisted op: result = a, no flag update.
- Flags:
  - ADD/ADDC: C = carry out of MSB, F = signed overflow, Z = result==0, N = result MSB, L = 0.
  - SUB: C = borrow (a<b unsigned), F = signed overflow, Z/N from result, L = 0.
  - CMP: L = a<b unsigned, N = a<b signed, Z = a==b, C = F = 0.
  - Logic/MOV/shift: C = F = L = 0, Z/N from result.
- Bypass:
  - Operand read in the accept cycle: if EX wb_valid and wb_dest matches Rdest or Rsrc, use wb_data instead of the regfile.
  - ADDC carry-in: if EX updates flags, use EX's computed C.
- Stall: EX register, regfile and flags all hold; no writes; nothing accepted. mem_in/ext_in continue to be sampled combinationally in EX.
- wb_valid = EX valid & wb_en & op != CMP.
- Reset: all registers, flags, EX valid, a_out, b_out, wb_dest and wb_data cleared to 0; wb_valid = 0. An in-flight EX instruction is discarded, with no write. Reset overrides stall and in_valid.

Test Plan:
1. Reset for 2 cycles -> all R = 0x0000, flags_out = 0, wb_valid = 0, in_ready = 1.
2. Back-to-back ADDI R1,#0x7F then ADDI R1,#0x01 (wb_en=1) -> second uses bypassed 0x007F; R1 = 0x0080, flags Z=0, N=0, F=0, C=0.
3. R2 = 0x7FFF; ADDI R2,#1 with flags_en -> R2 = 0x8000, F=1, N=1, C=0. Next cycle ADDC R3(0xFFFF),R4(0x0000) -> R3 = 0xFFFF (bypassed C=0). Separately, ADD 0xFFFF+0x0001 -> 0x0000, C=1, Z=1.
4. R3 = 0x0005, R4 = 0xFFFF, CMP R3,R4 with wb_en=1 -> L=1, N=0, Z=0, C=F=0; R3 unchanged; wb_valid = 0. LSHI R3 left 4 -> 0x0050.
5. src_sel=2, ext_in[15:0] = 0xBEEF, dest R5 -> R5 = 0xBEEF. src_sel=3, ext_in[31:16] = 0x1234 -> 0x1234. src_sel=1 with mem_in = 0xCAFE in EX cycle -> 0xCAFE.
6. Stall for 3 cycles with EX holding MOVI R6,#0x12 -> in_ready=0, R6 written only after stall drops. Reset asserted while EX is valid -> R6 stays 0x0000 and flags stay 0.

Source files
------------

// File: rtl/datapath_pipe.sv
// Register-file / ALU datapath with a one-stage execute pipeline, operand and carry bypass,
// valid/ready handshake and stall.
module datapath_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NIN   = 2,
    localparam int unsigned SELW = $clog2(NIN + 2)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            instr,
    input  logic [SELW-1:0]        src_sel,
    input  logic                   wb_en,
    input  logic                   flags_en,
    input  logic                   stall,
    input  logic [WIDTH-1:0]       mem_in,
    input  logic [NIN*WIDTH-1:0]   ext_in,
    output logic [WIDTH-1:0]       a_out,
    output logic [WIDTH-1:0]       b_out,
    output logic                   wb_valid,
    output logic [3:0]             wb_dest,
    output logic [WIDTH-1:0]       wb_data,
    output logic [4:0]             flags_out
);

    localparam int unsigned Msb = WIDTH - 1;

    localparam logic [3:0] OpAnd  = 4'h1;
    localparam logic [3:0] OpOr   = 4'h2;
    localparam logic [3:0] OpXor  = 4'h3;
    localparam logic [3:0] OpAdd  = 4'h5;
    localparam logic [3:0] OpAddc = 4'h7;
    localparam logic [3:0] OpSub  = 4'h9;
    localparam logic [3:0] OpCmp  = 4'hB;
    localparam logic [3:0] OpMov  = 4'hD;

    logic [WIDTH-1:0] regs_q [16];
    logic [4:0]       flags_q;

    logic             ex_valid_q;
    logic [WIDTH-1:0] ex_a_q, ex_b_q;
    logic [3:0]       ex_op_q, ex_dest_q;
    logic             ex_shift_q, ex_right_q;
    logic [4:0]       ex_amt_q;
    logic [SELW-1:0]  ex_src_q;
    logic             ex_wb_en_q, ex_flags_en_q, ex_cin_q;

    // Decode / operand read in the accept cycle
    logic [3:0]       opcode, rdest, opext, rsrc;
    logic [WIDTH-1:0] rd_a, rd_b, dec_b;
    logic [3:0]       dec_op;
    logic             dec_lsh, dec_lshi, dec_right, dec_cin;
    logic [4:0]       dec_amt;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] shifted, alu_res, result;
    logic [4:0]       alu_flags;
    logic             alu_listed, flags_upd;

    assign opcode = instr[15:12];
    assign rdest  = instr[11:8];
    assign opext  = instr[7:4];
    assign rsrc   = instr[3:0];

    assign rd_a = (wb_valid && wb_dest == rdest) ? wb_data : regs_q[rdest];
    assign rd_b = (wb_valid && wb_dest == rsrc)  ? wb_data : regs_q[rsrc];

    always_comb begin
        dec_lsh   = (opcode == 4'h8) && (opext == 4'h4);
        dec_lshi  = (opcode == 4'h8) && (opext[3:1] == 3'b000);
        dec_op    = (opcode == 4'h0) ? opext : opcode;
        dec_right = 1'b0;
        dec_amt   = 5'd0;
        if (opcode == 4'h0 || dec_lsh) begin
            dec_b = rd_b;
        end else if (dec_lshi) begin
            dec_b = {{(WIDTH-4){1'b0}}, rsrc};
        end else if (dec_op inside {OpAdd, OpAddc, OpSub, OpCmp}) begin
            dec_b = {{(WIDTH-8){instr[7]}}, instr[7:0]};
        end else begin
            dec_b = {{(WIDTH-8){1'b0}}, instr[7:0]};
        end
        // Register shift amount is a signed 5-bit count; keep direction plus magnitude.
        if (dec_lsh) begin
            dec_right = rd_b[4];
            dec_amt   = rd_b[4] ? (5'd0 - rd_b[4:0]) : rd_b[4:0];
        end else if (dec_lshi) begin
            dec_right = instr[4];
            dec_amt   = {1'b0, rsrc};
        end
    end

    assign dec_cin = flags_upd ? alu_flags[4] : flags_q[4];

    // Execute stage ALU
    always_comb begin
        sum = {1'b0, ex_a_q} + {1'b0, ex_b_q}
            + {{WIDTH{1'b0}}, (ex_op_q == OpAddc) & ex_cin_q};
        diff       = {1'b0, ex_a_q} - {1'b0, ex_b_q};
        shifted    = ex_right_q ? (ex_a_q >> ex_amt_q) : (ex_a_q << ex_amt_q);
        alu_res    = ex_a_q;
        alu_flags  = 5'd0;
        alu_listed = 1'b1;
        if (ex_shift_q) begin
            alu_res   = shifted;
            alu_flags = {3'b000, ~|shifted, shifted[Msb]};
        end else begin
            case (ex_op_q)
                OpAnd: alu_res = ex_a_q & ex_b_q;
                OpOr:  alu_res = ex_a_q | ex_b_q;
                OpXor: alu_res = ex_a_q ^ ex_b_q;
                OpMov: alu_res = ex_b_q;
                OpAdd, OpAddc: begin
                    alu_res   = sum[Msb:0];
                    alu_flags = {sum[WIDTH], 1'b0,
                                 (ex_a_q[Msb] == ex_b_q[Msb]) && (sum[Msb] != ex_a_q[Msb]),
                                 ~|sum[Msb:0], sum[Msb]};
                end
                OpSub: begin
                    alu_res   = diff[Msb:0];
                    alu_flags = {diff[WIDTH], 1'b0,
                                 (ex_a_q[Msb] != ex_b_q[Msb]) && (diff[Msb] != ex_a_q[Msb]),
                                 ~|diff[Msb:0], diff[Msb]};
                end
                OpCmp: begin
                    alu_res   = diff[Msb:0];
                    alu_flags = {1'b0, diff[WIDTH], 1'b0, ex_a_q == ex_b_q,
                                 $signed(ex_a_q) < $signed(ex_b_q)};
                end
                default: alu_listed = 1'b0;
            endcase
            if (ex_op_q inside {OpAnd, OpOr, OpXor, OpMov}) begin
                alu_flags = {3'b000, ~|alu_res, alu_res[Msb]};
            end
        end
    end

    // Source mux; selects beyond the last channel yield zero
    always_comb begin
        result = '0;
        if (ex_src_q == SELW'(0)) begin
            result = alu_res;
        end else if (ex_src_q == SELW'(1)) begin
            result = mem_in;
        end else begin
            for (int unsigned k = 0; k < NIN; k++) begin
                if (ex_src_q == SELW'(k + 2)) result = ext_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign flags_upd = ex_valid_q & ex_flags_en_q & alu_listed;
    assign wb_valid  = ex_valid_q & ex_wb_en_q & (ex_shift_q | (ex_op_q != OpCmp));
    assign wb_dest   = ex_dest_q;
    assign wb_data   = result;
    assign a_out     = ex_a_q;
    assign b_out     = ex_b_q;
    assign flags_out = flags_q;
    assign in_ready  = ~stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
            flags_q       <= 5'd0;
            ex_valid_q    <= 1'b0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_op_q       <= 4'd0;
            ex_dest_q     <= 4'd0;
            ex_shift_q    <= 1'b0;
            ex_right_q    <= 1'b0;
            ex_amt_q      <= 5'd0;
            ex_src_q      <= '0;
            ex_wb_en_q    <= 1'b0;
            ex_flags_en_q <= 1'b0;
            ex_cin_q      <= 1'b0;
        end else if (!stall) begin
            if (wb_valid)  regs_q[wb_dest] <= wb_data;
            if (flags_upd) flags_q <= alu_flags;
            ex_valid_q <= in_valid;
            if (in_valid) begin
                ex_a_q        <= rd_a;
                ex_b_q        <= dec_b;
                ex_op_q       <= dec_op;
                ex_dest_q     <= rdest;
                ex_shift_q    <= dec_lsh | dec_lshi;
                ex_right_q    <= dec_right;
                ex_amt_q      <= dec_amt;
                ex_src_q      <= src_sel;
                ex_wb_en_q    <= wb_en;
                ex_flags_en_q <= flags_en;
                ex_cin_q      <= dec_cin;
            end
        end
    end

endmodule
